duplex_mem_sched: RTL and testbench
===================================

Name: duplex_mem_sched

Overview:
- Per-channel duplex memory scheduler. Consumes per-access parity-fail and compare results from the error-detection logic, and decides which memory module (A/B) drives the channel.
- Counts per-module errors and drops to simplex on the surviving module at threshold. Halts on an unrecoverable error. Sequences software-commanded re-entry into duplex via a resync handshake.
- Instantiated twice at top level: one instance for data memory, one for instruction memory.

Parameters:
- CNT_W, 4, width of per-module error counters (saturating).
- ERR_THRESH, 3, count at which a module is retired. 0 = never retire (count only). Must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cyc_valid  in  1  one-cycle strobe: results for the current memory access valid
- err_a  in  1  module A parity fail (qualified by cyc_valid)
- err_b  in  1  module B parity fail (qualified by cyc_valid)
- cmp_miss  in  1  A/B data disagree, both parities good (qualified by cyc_valid)
- reinit  in  1  software pulse: restore duplex / clear counters
- sync_done  in  1  memory copy complete (from resync sequencer)
- sel_a  out  1  module A enabled
- sel_b  out  1  module B enabled
- use_b  out  1  channel output taken from B
- mode  out  2  0=DUPLEX 1=SIMPLEX_A 2=SIMPLEX_B 3=FAIL/RESYNC; see state output
- state  out  3  encoded FSM state, for telemetry
- err_cnt_a  out  CNT_W  A error count
- err_cnt_b  out  CNT_W  B error count
- switch_p  out  1  pulse: duplex→simplex transition
- dbl_err_p  out  1  pulse: simultaneous A and B parity fail
- miscmp_p  out  1  pulse: compare miss with good parity
- resync_req  out  1  held while awaiting sync_done
- halt  out  1  unrecoverable error, held

Behaviour:
- All outputs registered. Response appears on the cycle after cyc_valid or reinit. Pulses are one cycle wide.
- Reset: state DUPLEX, sel_a=sel_b=1, use_b=0, mode=0, counters 0, all pulses 0, resync_req=0, halt=0. Reset mid-RESYNC abandons the handshake (resync_req drops).
- States: DUPLEX, SIMPLEX_A, SIMPLEX_B, FAIL, RESYNC. Encoding lives in the package.
- DUPLEX on cyc_valid:
  - err_a only: cnt_a++ (saturate). use_b=1 for one cycle. If new cnt_a == ERR_THRESH (ERR_THRESH≠0): →SIMPLEX_B, switch_p.
  - err_b only: symmetric. use_b stays 0. At threshold: →SIMPLEX_A, switch_p.
  - Both: dbl_err_p, no count, stay in DUPLEX.
  - cmp_miss with no parity error: miscmp_p only.
  - Clean access: nothing changes. Counters never decay.
- SIMPLEX_A: sel_a=1, sel_b=0, use_b=0, mode=1. cyc_valid & err_a → FAIL. err_b and cmp_miss are ignored. Counters are frozen.
- SIMPLEX_B: mirror of SIMPLEX_A (use_b=1, mode=2). err_b → FAIL.
- FAIL: halt=1, mode=3. sel/use_b hold their last values. All cyc_valid inputs are ignored.
- reinit:
  - In DUPLEX: clear both counters, no state change.
  - In SIMPLEX_x or FAIL: →RESYNC, resync_req=1, halt cleared. Selects keep the last good side (from FAIL: A if cnt_a < cnt_b, else B).
- RESYNC:
  - cyc_valid results are ignored.
  - sync_done → DUPLEX, counters cleared, resync_req=0, sel_a=sel_b=1, use_b=0.
  - A further reinit in RESYNC is ignored.
  - sync_done outside RESYNC is ignored.
- Simultaneity:
  - reinit and cyc_valid in the same cycle: reinit wins, and that access's errors are discarded.
  - sync_done and reinit in the same cycle in RESYNC: sync_done wins.
- Counters saturate at 2^CNT_W-1. With ERR_THRESH=0 the block never leaves DUPLEX due to counting.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum, and mode codes (DUPLEX/SIMPLEX_A/SIMPLEX_B/FAIL).
  - default CNT_W and ERR_THRESH constants.
- One sub-module, err_sat_cnt (CNT_W): increment, synchronous clear, saturation, "hit threshold" compare. Instantiated once per module side.

Test Plan:
- Reset, then 3 cyc_valid pulses with err_a=1 → cnt_a 1,2,3; use_b pulses each time; switch_p on the 3rd; mode=2, sel_a=0, sel_b=1.
- In SIMPLEX_B, cyc_valid with err_a=1 → no change. Then err_b=1 → halt=1, mode=3. Further errors are ignored.
- FAIL with cnt_a=3, cnt_b=1; reinit → resync_req=1, halt=0, use_b=1. sync_done 5 cycles later → DUPLEX, both counters 0, sel_a=sel_b=1, use_b=0.
- DUPLEX, cyc_valid with err_a=err_b=1 → dbl_err_p only, counters 0. cmp_miss=1 alone → miscmp_p only.
- cyc_valid with err_b=1 and reinit in the same cycle, cnt_b=2 → cnt_b=0, no switch_p. rst asserted during RESYNC → all outputs at reset values the next cycle.
- CNT_W=2, ERR_THRESH=0: 6 err_a accesses → cnt_a saturates at 3, stays in DUPLEX, no switch_p.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state, mode and default-parameter definitions for duplex_mem_sched.
// Revision 1.0
`default_nettype none

package dmem_pkg;

  typedef enum logic [2:0] {
    ST_DUPLEX    = 3'd0,
    ST_SIMPLEX_A = 3'd1,
    ST_SIMPLEX_B = 3'd2,
    ST_FAIL      = 3'd3,
    ST_RESYNC    = 3'd4
  } state_e;

  localparam logic [1:0] MODE_DUPLEX    = 2'd0;
  localparam logic [1:0] MODE_SIMPLEX_A = 2'd1;
  localparam logic [1:0] MODE_SIMPLEX_B = 2'd2;
  localparam logic [1:0] MODE_FAIL      = 2'd3;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_ERR_THRESH = 3;

endpackage

`default_nettype wire

// File: rtl/duplex_mem_sched_err_sat_cnt.sv
// err_sat_cnt: saturating per-module error counter with look-ahead threshold hit.
// Revision 1.0
`default_nettype none

module err_sat_cnt #(
  parameter int CNT_W  = 4,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_THR     = CNT_W'(THRESH);
  localparam logic             C_THR_EN  = (THRESH != 0);

  logic [CNT_W-1:0] w_next;

  assign w_next = (cnt == C_CNT_MAX) ? cnt : cnt + 1'b1;

  // Hit is judged on the post-increment value so the scheduler can switch in the same cycle.
  assign hit = C_THR_EN && inc && (w_next == C_THR);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/duplex_mem_sched.sv
// duplex_mem_sched: per-channel A/B duplex memory scheduler with simplex fallback and resync.
// Revision 1.0
`default_nettype none

module duplex_mem_sched
  import dmem_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_valid,
  input  logic             err_a,
  input  logic             err_b,
  input  logic             cmp_miss,
  input  logic             reinit,
  input  logic             sync_done,
  output logic             sel_a,
  output logic             sel_b,
  output logic             use_b,
  output logic [1:0]       mode,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic             switch_p,
  output logic             dbl_err_p,
  output logic             miscmp_p,
  output logic             resync_req,
  output logic             halt
);

  state_e st_q;

  logic w_dup_valid;
  logic w_inc_a;
  logic w_inc_b;
  logic w_clr;
  logic w_hit_a;
  logic w_hit_b;

  // reinit in the same cycle as an access discards that access's results.
  assign w_dup_valid = (st_q == ST_DUPLEX) && cyc_valid && !reinit;
  assign w_inc_a     = w_dup_valid && err_a && !err_b;
  assign w_inc_b     = w_dup_valid && err_b && !err_a;
  assign w_clr       = ((st_q == ST_DUPLEX) && reinit) || ((st_q == ST_RESYNC) && sync_done);

  assign state = st_q;

  err_sat_cnt #(.CNT_W(CNT_W), .THRESH(ERR_THRESH)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_inc_a),
    .cnt (err_cnt_a),
    .hit (w_hit_a)
  );

  err_sat_cnt #(.CNT_W(CNT_W), .THRESH(ERR_THRESH)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_inc_b),
    .cnt (err_cnt_b),
    .hit (w_hit_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_DUPLEX;
      sel_a      <= 1'b1;
      sel_b      <= 1'b1;
      use_b      <= 1'b0;
      mode       <= MODE_DUPLEX;
      switch_p   <= 1'b0;
      dbl_err_p  <= 1'b0;
      miscmp_p   <= 1'b0;
      resync_req <= 1'b0;
      halt       <= 1'b0;
    end else begin
      switch_p  <= 1'b0;
      dbl_err_p <= 1'b0;
      miscmp_p  <= 1'b0;
      case (st_q)
        ST_DUPLEX: begin
          use_b <= 1'b0;
          if (w_dup_valid) begin
            if (err_a && err_b) begin
              dbl_err_p <= 1'b1;
            end else if (err_a) begin
              use_b <= 1'b1;
              if (w_hit_a) begin
                st_q     <= ST_SIMPLEX_B;
                sel_a    <= 1'b0;
                mode     <= MODE_SIMPLEX_B;
                switch_p <= 1'b1;
              end
            end else if (err_b) begin
              if (w_hit_b) begin
                st_q     <= ST_SIMPLEX_A;
                sel_b    <= 1'b0;
                mode     <= MODE_SIMPLEX_A;
                switch_p <= 1'b1;
              end
            end else if (cmp_miss) begin
              miscmp_p <= 1'b1;
            end
          end
        end
        ST_SIMPLEX_A: begin
          if (reinit) begin
            st_q       <= ST_RESYNC;
            resync_req <= 1'b1;
            halt       <= 1'b0;
            mode       <= MODE_FAIL;
          end else if (cyc_valid && err_a) begin
            st_q <= ST_FAIL;
            halt <= 1'b1;
            mode <= MODE_FAIL;
          end
        end
        ST_SIMPLEX_B: begin
          if (reinit) begin
            st_q       <= ST_RESYNC;
            resync_req <= 1'b1;
            halt       <= 1'b0;
            mode       <= MODE_FAIL;
          end else if (cyc_valid && err_b) begin
            st_q <= ST_FAIL;
            halt <= 1'b1;
            mode <= MODE_FAIL;
          end
        end
        ST_FAIL: begin
          if (reinit) begin
            st_q       <= ST_RESYNC;
            resync_req <= 1'b1;
            halt       <= 1'b0;
            // Keep the side with fewer recorded errors; ties go to B.
            if (err_cnt_a < err_cnt_b) begin
              sel_a <= 1'b1;
              sel_b <= 1'b0;
              use_b <= 1'b0;
            end else begin
              sel_a <= 1'b0;
              sel_b <= 1'b1;
              use_b <= 1'b1;
            end
          end
        end
        ST_RESYNC: begin
          if (sync_done) begin
            st_q       <= ST_DUPLEX;
            resync_req <= 1'b0;
            sel_a      <= 1'b1;
            sel_b      <= 1'b1;
            use_b      <= 1'b0;
            mode       <= MODE_DUPLEX;
          end
        end
        default: begin
          st_q <= ST_DUPLEX;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_duplex_mem_sched.sv
// tb_duplex_mem_sched: directed self-checking bench for duplex_mem_sched.
// Revision 1.0
`default_nettype none

module tb_duplex_mem_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cyc_valid = 1'b0;
  logic       err_a = 1'b0;
  logic       err_b = 1'b0;
  logic       cmp_miss = 1'b0;
  logic       reinit = 1'b0;
  logic       sync_done = 1'b0;

  logic       sel_a, sel_b, use_b, switch_p, dbl_err_p, miscmp_p, resync_req, halt;
  logic [1:0] mode;
  logic [2:0] state;
  logic [3:0] err_cnt_a, err_cnt_b;

  logic       s2_sel_a, s2_sel_b, s2_use_b, s2_switch_p, s2_dbl_err_p, s2_miscmp_p;
  logic       s2_resync_req, s2_halt;
  logic [1:0] s2_mode;
  logic [2:0] s2_state;
  logic [1:0] s2_err_cnt_a, s2_err_cnt_b;

  int checks = 0;
  int failures = 0;

  // {state, mode, sel_a, sel_b, use_b, halt, resync_req}
  logic [9:0] stat;
  logic [2:0] pul;
  assign stat = {state, mode, sel_a, sel_b, use_b, halt, resync_req};
  assign pul  = {switch_p, dbl_err_p, miscmp_p};

  always #5 clk = ~clk;

  duplex_mem_sched dut (
    .clk(clk), .rst(rst), .cyc_valid(cyc_valid), .err_a(err_a), .err_b(err_b),
    .cmp_miss(cmp_miss), .reinit(reinit), .sync_done(sync_done),
    .sel_a(sel_a), .sel_b(sel_b), .use_b(use_b), .mode(mode), .state(state),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .switch_p(switch_p),
    .dbl_err_p(dbl_err_p), .miscmp_p(miscmp_p), .resync_req(resync_req), .halt(halt)
  );

  duplex_mem_sched #(.CNT_W(2), .ERR_THRESH(0)) dut2 (
    .clk(clk), .rst(rst), .cyc_valid(cyc_valid), .err_a(err_a), .err_b(err_b),
    .cmp_miss(cmp_miss), .reinit(reinit), .sync_done(sync_done),
    .sel_a(s2_sel_a), .sel_b(s2_sel_b), .use_b(s2_use_b), .mode(s2_mode), .state(s2_state),
    .err_cnt_a(s2_err_cnt_a), .err_cnt_b(s2_err_cnt_b), .switch_p(s2_switch_p),
    .dbl_err_p(s2_dbl_err_p), .miscmp_p(s2_miscmp_p), .resync_req(s2_resync_req),
    .halt(s2_halt)
  );

  // One clock with the given inputs held across the edge; outputs are sampled 1ns after it.
  task automatic apply(input logic cv, input logic ea, input logic eb, input logic cm,
                       input logic ri, input logic sd);
    cyc_valid = cv; err_a = ea; err_b = eb; cmp_miss = cm; reinit = ri; sync_done = sd;
    @(posedge clk);
    #1;
    cyc_valid = 0; err_a = 0; err_b = 0; cmp_miss = 0; reinit = 0; sync_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (stat !== {3'd0, 2'd0, 5'b11000}) begin
      failures++; $display("FAIL reset_stat got=%b exp=%b", stat, {3'd0, 2'd0, 5'b11000});
    end
    checks++;
    if ({pul, err_cnt_a, err_cnt_b} !== 11'd0) begin
      failures++; $display("FAIL reset_pulse_cnt got=%b exp=0", {pul, err_cnt_a, err_cnt_b});
    end
  endtask

  task automatic test_err_a_switch();
    apply(1, 0, 1, 0, 0, 0);
    checks++;
    if ({stat, pul, err_cnt_b} !== {3'd0, 2'd0, 5'b11000, 3'b000, 4'd1}) begin
      failures++; $display("FAIL err_b_count got=%b exp=%b", {stat, pul, err_cnt_b},
                           {3'd0, 2'd0, 5'b11000, 3'b000, 4'd1});
    end
    for (int i = 1; i <= 3; i++) begin
      apply(1, 1, 0, 0, 0, 0);
      checks++;
      if (err_cnt_a !== 4'(i)) begin
        failures++; $display("FAIL err_a_cnt%0d got=%0d exp=%0d", i, err_cnt_a, i);
      end
      checks++;
      if (i < 3) begin
        if ({stat, pul} !== {3'd0, 2'd0, 5'b11100, 3'b000}) begin
          failures++; $display("FAIL err_a_step%0d got=%b exp=%b", i, {stat, pul},
                               {3'd0, 2'd0, 5'b11100, 3'b000});
        end
        apply(0, 0, 0, 0, 0, 0);
        checks++;
        if (use_b !== 1'b0) begin
          failures++; $display("FAIL use_b_release%0d got=%b exp=0", i, use_b);
        end
      end else begin
        if ({stat, pul} !== {3'd2, 2'd2, 5'b01100, 3'b100}) begin
          failures++; $display("FAIL switch_to_b got=%b exp=%b", {stat, pul},
                               {3'd2, 2'd2, 5'b01100, 3'b100});
        end
      end
    end
  endtask

  task automatic test_simplex_b();
    apply(1, 1, 0, 0, 0, 0);
    checks++;
    if ({stat, pul, err_cnt_a} !== {3'd2, 2'd2, 5'b01100, 3'b000, 4'd3}) begin
      failures++; $display("FAIL sb_ignore_a got=%b exp=%b", {stat, pul, err_cnt_a},
                           {3'd2, 2'd2, 5'b01100, 3'b000, 4'd3});
    end
    apply(1, 0, 1, 0, 0, 0);
    checks++;
    if ({stat, err_cnt_b} !== {3'd3, 2'd3, 5'b01110, 4'd1}) begin
      failures++; $display("FAIL sb_to_fail got=%b exp=%b", {stat, err_cnt_b},
                           {3'd3, 2'd3, 5'b01110, 4'd1});
    end
    apply(1, 1, 1, 1, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    checks++;
    if ({stat, pul, err_cnt_a, err_cnt_b} !== {3'd3, 2'd3, 5'b01110, 3'b000, 4'd3, 4'd1}) begin
      failures++; $display("FAIL fail_ignores got=%b exp=%b", {stat, pul, err_cnt_a, err_cnt_b},
                           {3'd3, 2'd3, 5'b01110, 3'b000, 4'd3, 4'd1});
    end
  endtask

  task automatic test_resync();
    apply(0, 0, 0, 0, 1, 0);
    checks++;
    if (stat !== {3'd4, 2'd3, 5'b01101}) begin
      failures++; $display("FAIL resync_enter got=%b exp=%b", stat, {3'd4, 2'd3, 5'b01101});
    end
    apply(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0);
    checks++;
    if ({stat, err_cnt_a, err_cnt_b} !== {3'd4, 2'd3, 5'b01101, 4'd3, 4'd1}) begin
      failures++; $display("FAIL resync_hold got=%b exp=%b", {stat, err_cnt_a, err_cnt_b},
                           {3'd4, 2'd3, 5'b01101, 4'd3, 4'd1});
    end
    apply(0, 0, 0, 0, 1, 1);
    checks++;
    if ({stat, err_cnt_a, err_cnt_b} !== {3'd0, 2'd0, 5'b11000, 4'd0, 4'd0}) begin
      failures++; $display("FAIL resync_done got=%b exp=%b", {stat, err_cnt_a, err_cnt_b},
                           {3'd0, 2'd0, 5'b11000, 4'd0, 4'd0});
    end
  endtask

  task automatic test_dbl_miscmp();
    apply(1, 1, 1, 0, 0, 0);
    checks++;
    if ({stat, pul, err_cnt_a, err_cnt_b} !== {3'd0, 2'd0, 5'b11000, 3'b010, 8'd0}) begin
      failures++; $display("FAIL dbl_err got=%b exp=%b", {stat, pul, err_cnt_a, err_cnt_b},
                           {3'd0, 2'd0, 5'b11000, 3'b010, 8'd0});
    end
    apply(1, 0, 0, 1, 0, 0);
    checks++;
    if ({stat, pul} !== {3'd0, 2'd0, 5'b11000, 3'b001}) begin
      failures++; $display("FAIL miscmp got=%b exp=%b", {stat, pul}, {3'd0, 2'd0, 5'b11000, 3'b001});
    end
    apply(1, 1, 0, 1, 0, 0);
    checks++;
    if ({pul, err_cnt_a} !== {3'b000, 4'd1}) begin
      failures++; $display("FAIL miscmp_masked got=%b exp=%b", {pul, err_cnt_a}, {3'b000, 4'd1});
    end
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (pul !== 3'b000) begin
      failures++; $display("FAIL pulse_width got=%b exp=000", pul);
    end
  endtask

  task automatic test_reinit_wins();
    apply(1, 0, 1, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 0);
    checks++;
    if ({err_cnt_a, err_cnt_b} !== {4'd1, 4'd2}) begin
      failures++; $display("FAIL pre_reinit_cnt got=%b exp=%b", {err_cnt_a, err_cnt_b}, {4'd1, 4'd2});
    end
    apply(1, 0, 1, 0, 1, 0);
    checks++;
    if ({stat, pul, err_cnt_a, err_cnt_b} !== {3'd0, 2'd0, 5'b11000, 3'b000, 8'd0}) begin
      failures++; $display("FAIL reinit_wins got=%b exp=%b", {stat, pul, err_cnt_a, err_cnt_b},
                           {3'd0, 2'd0, 5'b11000, 3'b000, 8'd0});
    end
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (stat !== {3'd0, 2'd0, 5'b11000}) begin
      failures++; $display("FAIL sync_done_ignored got=%b exp=%b", stat, {3'd0, 2'd0, 5'b11000});
    end
  endtask

  task automatic test_reset_in_resync();
    for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 0, 0);
    checks++;
    if ({stat, pul} !== {3'd1, 2'd1, 5'b10000, 3'b100}) begin
      failures++; $display("FAIL switch_to_a got=%b exp=%b", {stat, pul}, {3'd1, 2'd1, 5'b10000, 3'b100});
    end
    apply(0, 0, 0, 0, 1, 0);
    checks++;
    if (stat !== {3'd4, 2'd3, 5'b10001}) begin
      failures++; $display("FAIL sa_resync got=%b exp=%b", stat, {3'd4, 2'd3, 5'b10001});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({stat, pul, err_cnt_a, err_cnt_b} !== {3'd0, 2'd0, 5'b11000, 3'b000, 8'd0}) begin
      failures++; $display("FAIL rst_in_resync got=%b exp=%b", {stat, pul, err_cnt_a, err_cnt_b},
                           {3'd0, 2'd0, 5'b11000, 3'b000, 8'd0});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      apply(1, 1, 0, 0, 0, 0);
      exp_cnt = (i < 3) ? 2'(i) : 2'd3;
      checks++;
      if ({s2_err_cnt_a, s2_state, s2_switch_p} !== {exp_cnt, 3'd0, 1'b0}) begin
        failures++; $display("FAIL sat_step%0d got=%b exp=%b", i,
                             {s2_err_cnt_a, s2_state, s2_switch_p}, {exp_cnt, 3'd0, 1'b0});
      end
    end
    checks++;
    if ({s2_sel_a, s2_sel_b, s2_mode} !== 4'b1100) begin
      failures++; $display("FAIL sat_duplex got=%b exp=1100", {s2_sel_a, s2_sel_b, s2_mode});
    end
  endtask

  initial begin
    test_reset();
    test_err_a_switch();
    test_simplex_b();
    test_resync();
    test_dbl_miscmp();
    test_reinit_wins();
    test_reset_in_resync();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
